// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Round-robin writeback arbiter for the single write port of
//               the register file, with a pending-write scoreboard for RAW
//               hazard detection.
//               Requesters use valid/ready handshakes. The winning write is
//               registered for one cycle and then presented as wEn/Rw/busW.
//               Writes to x0 complete the handshake but are dropped.
// Ports       : clk, rst                  clock, synchronous active-high reset
//               req_valid/req_ready       per-requester handshake
//               req_addr/req_data         packed per-requester dest and data
//               issue_en/issue_rd         marks a destination as pending
//               chk_ra/chk_rb -> busy_a/b scoreboard queries (combinational)
//               wEn/Rw/busW               registered register-file write port
// Config      : RF_WB_BYPASS_EN adds fwd_a/b_valid and fwd_a/b_data, which
//               forward the write being committed and mask busy_a/b for it.
// Revision    : 1.0  initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_en,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic [ADDR_W-1:0]         chk_ra,
  input  logic [ADDR_W-1:0]         chk_rb,
  output logic                      busy_a,
  output logic                      busy_b,
  output logic                      wEn,
  output logic [ADDR_W-1:0]         Rw,
  output logic [DATA_W-1:0]         busW
`ifdef RF_WB_BYPASS_EN
  ,
  output logic                      fwd_a_valid,
  output logic                      fwd_b_valid,
  output logic [DATA_W-1:0]         fwd_a_data,
  output logic [DATA_W-1:0]         fwd_b_data
`endif
);

  localparam int C_PTR_W    = (NUM_REQ > 2) ? 2 : 1;
  localparam int C_NUM_REGS = 1 << ADDR_W;

  logic [C_PTR_W-1:0]    r_ptr;
  logic [C_PTR_W-1:0]    w_ptrNext;
  logic [C_PTR_W-1:0]    w_grantIdx;
  logic                  w_grantAny;
  logic [ADDR_W-1:0]     w_selAddr;
  logic [DATA_W-1:0]     w_selData;
  logic [C_NUM_REGS-1:0] r_busy;
  logic [C_NUM_REGS-1:0] w_busyNext;
  logic                  r_wEn;
  logic [ADDR_W-1:0]     r_rw;
  logic [DATA_W-1:0]     r_busW;
  logic                  w_fwdA;
  logic                  w_fwdB;

  // Round-robin search starting at r_ptr; the first valid requester wins.
  // Reset suppresses all grants so no handshake completes during reset.
  always_comb begin
    int idx;
    idx        = 0;
    w_grantAny = 1'b0;
    w_grantIdx = '0;
    req_ready  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_grantAny && req_valid[idx] && !rst) begin
        w_grantAny = 1'b1;
        w_grantIdx = idx[C_PTR_W-1:0];
      end
    end
    if (w_grantAny) begin
      req_ready[w_grantIdx] = 1'b1;
    end
  end

  assign w_ptrNext = (int'(w_grantIdx) == NUM_REQ - 1) ? '0 : w_grantIdx + C_PTR_W'(1);
  assign w_selAddr = req_addr[int'(w_grantIdx)*ADDR_W +: ADDR_W];
  assign w_selData = req_data[int'(w_grantIdx)*DATA_W +: DATA_W];

  // Scoreboard update: commit clears, issue sets afterwards so a new producer
  // to the register being committed keeps it pending. x0 is never pending.
  always_comb begin
    w_busyNext = r_busy;
    if (r_wEn) begin
      w_busyNext[r_rw] = 1'b0;
    end
    if (issue_en && (issue_rd != '0)) begin
      w_busyNext[issue_rd] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_busy <= '0;
      r_wEn  <= 1'b0;
      r_rw   <= '0;
      r_busW <= '0;
    end else begin
      r_busy <= w_busyNext;
      // A granted x0 write completes its handshake but never enables the port.
      r_wEn  <= w_grantAny && (w_selAddr != '0);
      if (w_grantAny) begin
        r_ptr  <= w_ptrNext;
        r_rw   <= w_selAddr;
        r_busW <= w_selData;
      end
    end
  end

  assign wEn  = r_wEn;
  assign Rw   = r_rw;
  assign busW = r_busW;

`ifdef RF_WB_BYPASS_EN
  // The commit-cycle data is already on busW, so a consumer of that register
  // can take it from here instead of waiting a cycle for the scoreboard.
  assign w_fwdA      = r_wEn && (r_rw == chk_ra) && (r_rw != '0);
  assign w_fwdB      = r_wEn && (r_rw == chk_rb) && (r_rw != '0);
  assign fwd_a_valid = w_fwdA;
  assign fwd_b_valid = w_fwdB;
  assign fwd_a_data  = r_busW;
  assign fwd_b_data  = r_busW;
`else
  assign w_fwdA = 1'b0;
  assign w_fwdB = 1'b0;
`endif

  assign busy_a = r_busy[chk_ra] && !w_fwdA;
  assign busy_b = r_busy[chk_rb] && !w_fwdB;

endmodule
`default_nettype wire
